dram_chip: RTL and testbench

- Behavioural model of one DDR4 DRAM device for the emulation platform.
- It holds BANKGROUPS x BANKSPERGROUP independent bank arrays of ROWS x COLS words, each DEVICE_WIDTH bits wide.
- Every bank has its own address, write-enable and data ports, so all banks can be accessed in parallel each clock cycle.
- It sits under the rank/channel FSM, which drives the per-bank row, column, rd_o_wr and data lines.

---
 rtl/dram_chip_pkg.sv | 14 +
 rtl/dram_bank.sv | 28 ++
 rtl/dram_chip.sv | 37 +++
 tb/tb_dram_chip.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dram_chip_pkg.sv
// dram_chip_pkg: default geometry of the DDR4 device model and derived counts.
package dram_chip_pkg;
    localparam int BGWIDTH       = 2;
    localparam int BAWIDTH       = 2;
    localparam int ADDRWIDTH     = 17;
    localparam int COLWIDTH      = 10;
    localparam int DEVICE_WIDTH  = 4;
    // Burst length belongs to the controller; the datapath never looks at it.
    localparam int BL            = 8;
    localparam int BANKGROUPS    = 2 ** BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** BAWIDTH;
    localparam int ROWS          = 2 ** ADDRWIDTH;
    localparam int COLS          = 2 ** COLWIDTH;
endpackage

// File: rtl/dram_bank.sv
// dram_bank: one bank array, single-port synchronous RAM with registered,
// read-before-write output that clears asynchronously on reset.
module dram_bank import dram_chip_pkg::*; #(
    parameter int RW = ADDRWIDTH,
    parameter int CW = COLWIDTH,
    parameter int DW = DEVICE_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] column,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0]    mem [2 ** (RW + CW)];
    logic [RW+CW-1:0] addr;
    assign addr = {row, column};
    // Contents are deliberately left untouched by reset; only the write is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            if (we) mem[addr] <= din;
            dout <= mem[addr];
        end
    end
endmodule

// File: rtl/dram_chip.sv
// dram_chip: behavioural DDR4 device, a grid of fully independent banks each
// with its own address, write-enable and data ports.
module dram_chip #(
    parameter int  BGWIDTH       = dram_chip_pkg::BGWIDTH,
    parameter int  BAWIDTH       = dram_chip_pkg::BAWIDTH,
    parameter int  ADDRWIDTH     = dram_chip_pkg::ADDRWIDTH,
    parameter int  COLWIDTH      = dram_chip_pkg::COLWIDTH,
    parameter int  DEVICE_WIDTH  = dram_chip_pkg::DEVICE_WIDTH,
    localparam int BANKGROUPS    = 2 ** BGWIDTH,
    localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_o_wr [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    output logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [ADDRWIDTH-1:0]    row     [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [COLWIDTH-1:0]     column  [BANKGROUPS-1:0][BANKSPERGROUP-1:0]
);
    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_bg
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_ba
            dram_bank #(
                .RW(ADDRWIDTH),
                .CW(COLWIDTH),
                .DW(DEVICE_WIDTH)
            ) u_bank (
                .clk   (clk),
                .rst   (rst),
                .we    (rd_o_wr[g][b]),
                .row   (row[g][b]),
                .column(column[g][b]),
                .din   (dqin[g][b]),
                .dout  (dqout[g][b])
            );
        end
    end
endmodule

// File: tb/tb_dram_chip.sv
// tb_dram_chip: directed checks of bank independence, read latency,
// read-before-write, asynchronous reset and corner addresses.
module tb_dram_chip;
    // Row width is reduced so sixteen full bank arrays fit comfortably in simulation.
    localparam int BG = 2, BA = 2, AW = 11, CW = 10, DW = 4;
    localparam int NG = 2 ** BG, NB = 2 ** BA;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_o_wr [NG-1:0][NB-1:0];
    logic [DW-1:0] dqin    [NG-1:0][NB-1:0];
    logic [DW-1:0] dqout   [NG-1:0][NB-1:0];
    logic [AW-1:0] row     [NG-1:0][NB-1:0];
    logic [CW-1:0] column  [NG-1:0][NB-1:0];
    int checks = 0, failures = 0;
    logic [DW-1:0] burst [8] = '{4'h9, 4'h2, 4'h7, 4'hE, 4'h0, 4'hB, 4'h4, 4'hD};

    dram_chip #(
        .BGWIDTH(BG), .BAWIDTH(BA), .ADDRWIDTH(AW), .COLWIDTH(CW), .DEVICE_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .rd_o_wr(rd_o_wr), .dqin(dqin),
        .dqout(dqout), .row(row), .column(column)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                rd_o_wr[g][b] = 1'b0;
                dqin[g][b]    = '0;
                row[g][b]     = '0;
                column[g][b]  = '0;
            end
    endtask

    task automatic access(input int g, input int b, input logic we, input int r, input int c, input logic [DW-1:0] d);
        rd_o_wr[g][b] = we;
        row[g][b]     = AW'(r);
        column[g][b]  = CW'(c);
        dqin[g][b]    = d;
    endtask

    initial begin
        idle();
        tick();
        tick();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                check($sformatf("reset_dq[%0d][%0d]", g, b), dqout[g][b], '0);
        rst = 1'b0;
        // Preload row 0 / column 0 of every bank with a bank-unique value.
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                access(g, b, 1'b1, 0, 0, DW'(g * NB + b));
        tick();
        idle();
        tick();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                check($sformatf("preload[%0d][%0d]", g, b), dqout[g][b], DW'(g * NB + b));
        for (int i = 0; i < 8; i++) begin
            access(1, 1, 1'b1, 1, i, burst[i]);
            tick();
            for (int g = 0; g < NG; g++)
                for (int b = 0; b < NB; b++)
                    if (!(g == 1 && b == 1))
                        check($sformatf("wr_burst_other[%0d][%0d]_beat%0d", g, b, i), dqout[g][b], DW'(g * NB + b));
        end
        for (int i = 0; i < 8; i++) begin
            access(1, 1, 1'b0, 1, i, '0);
            tick();
            check($sformatf("rd_burst_beat%0d", i), dqout[1][1], burst[i]);
        end
        idle();
        access(0, 0, 1'b1, 5, 3, 4'hA);
        access(3, 3, 1'b1, 5, 3, 4'h5);
        tick();
        access(0, 0, 1'b0, 5, 3, '0);
        access(3, 3, 1'b0, 5, 3, '0);
        tick();
        check("isolation_b00", dqout[0][0], 4'hA);
        check("isolation_b33", dqout[3][3], 4'h5);
        idle();
        access(2, 1, 1'b1, 7, 9, 4'h3);
        tick();
        access(2, 1, 1'b1, 7, 9, 4'hC);
        tick();
        check("rbw_old", dqout[2][1], 4'h3);
        access(2, 1, 1'b0, 7, 9, '0);
        tick();
        check("rbw_new", dqout[2][1], 4'hC);
        idle();
        access(1, 1, 1'b0, 1, 2, '0);
        tick();
        check("pre_reset_read", dqout[1][1], burst[2]);
        #2 rst = 1'b1;
        #1;
        check("async_reset_b11", dqout[1][1], '0);
        check("async_reset_b00", dqout[0][0], '0);
        // A write attempted during reset must not land.
        access(1, 1, 1'b1, 1, 2, ~burst[2]);
        tick();
        tick();
        check("reset_hold_b11", dqout[1][1], '0);
        access(1, 1, 1'b0, 1, 2, '0);
        #3 rst = 1'b0;
        #1;
        check("post_reset_before_edge", dqout[1][1], '0);
        tick();
        check("post_reset_read", dqout[1][1], burst[2]);
        access(1, 1, 1'b1, 2 ** AW - 1, 2 ** CW - 1, 4'hF);
        tick();
        access(1, 1, 1'b0, 2 ** AW - 1, 2 ** CW - 1, '0);
        tick();
        check("corner_max", dqout[1][1], 4'hF);
        access(1, 1, 1'b0, 0, 0, '0);
        tick();
        check("corner_zero_unchanged", dqout[1][1], 4'h5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
